fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Consumer-side companion to the 4-bit `fifo`. It drains the FIFO through its `pop`/`q`/`empty` interface and transmits each word as an asynchronous serial frame: start bit, data LSB first, stop bit. The FIFO remains the producer-facing buffer and this block is its reader. Together they form the transmit path for nibble streams leaving the design.

## Interface
Parameters:
- `DATA_W`, 4, width of each FIFO word and the number of data bits per frame
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range 1..255

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `enable`  in  1  when high, the block may start new frames
- `empty`  in  1  FIFO empty flag
- `q`  in  DATA_W  FIFO read data; valid the cycle after `pop`
- `pop`  out  1  FIFO read strobe; one-cycle pulse per word
- `tx`  out  1  serial line; idles high
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse in the last cycle of each stop bit
- `frame_cnt`  out  8  number of completed frames; wraps from 255 to 0

## Operation
- State machine states are IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. Go to POP when `enable`=1 and `empty`=0.
- POP: `pop`=1 for exactly this one cycle, then go to LOAD. `pop` is decoded from the registered state only and is never driven by `empty` combinationally.
- LOAD: capture `q` into the shift register, then go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: `tx`=shift[0]. Shift right every `CLKS_PER_BIT` cycles, for a total of `DATA_W` bits.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. In the last cycle, `frame_done`=1 and `frame_cnt` increments. Then go to IDLE.
- Bit timing uses a cycle counter sized $clog2(CLKS_PER_BIT+1), cleared on every state change. The bit index counter is sized $clog2(DATA_W+1).
- `enable` dropping mid-frame has no effect; the current frame completes. No new POP follows while `enable`=0.
- `empty` changes after POP are ignored for the frame in flight.
- `tx` is a registered output and must be glitch-free.
- Reset values: state=IDLE, `tx`=1, `pop`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, shift register=0, both counters=0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously). The partial frame is abandoned and the popped word is lost.

## Timing
- Edge N: IDLE sees `enable`&!`empty`. Cycle N+1: `pop`=1. N+2: LOAD. N+3: `tx` falls.
- Frame on the line lasts (DATA_W+2)×CLKS_PER_BIT cycles; 24 cycles at the defaults.
- Back-to-back frames take at least 1 IDLE + 1 POP + 1 LOAD cycle between stop-bit end and the next start bit. Continuous throughput is one word per 3+(DATA_W+2)×CLKS_PER_BIT cycles, which is 27 at the defaults.
- `busy` rises in the cycle `pop` is high and falls in the cycle after `frame_done`.
- At most one `pop` is issued per frame. `pop` is never asserted while `empty`=1 was sampled in IDLE.

## Test plan
- Reset, then `enable`=1 with `empty`=1 held for 50 cycles -> `pop`=0, `tx`=1, `busy`=0, `frame_cnt`=0 throughout.
- One word `q`=4'hA (1010b) with defaults -> single `pop`. Then `tx` sequence in 4-cycle bits: 0 (start), 0, 1, 0, 1, 1 (stop). `frame_done` pulses once and `frame_cnt`=1.
- FIFO pre-filled with 1..15 via push, `enable`=1 -> 15 frames carrying 1..15 in order. `pop` pulses spaced exactly 27 cycles apart. `frame_cnt`=15, and `empty` stops further pops.
- `enable` dropped during the DATA bit 1 of frame 2 -> frame 2 completes intact and no third `pop` occurs. Re-raising `enable` resumes with word 3.
- `reset` asserted (low) during STOP of a frame -> `tx`=1, `busy`=0, `frame_cnt`=0 immediately. After release, the next word transmits cleanly.
- `CLKS_PER_BIT`=1, `DATA_W`=4, two words 4'h5 and 4'hF -> frames of 6 cycles each, 9-cycle pop spacing, correct LSB-first bits.

Source files
------------

// File: rtl/fifo_serial_tx_if.sv
// ============================================================================
// Module   : fifo_serial_tx_if
// Purpose  : FIFO read-side bundle (pop / q / empty) shared by FIFO and reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_serial_tx_if #(
    parameter int DATA_W = 4
);
    logic              empty;
    logic [DATA_W-1:0] q;
    logic              pop;

    // master = the reader that drains the FIFO
    modport master (output pop, input empty, input q);
    modport slave  (input pop, output empty, output q);
endinterface

`default_nettype wire

// File: rtl/fifo_serial_tx.sv
// ============================================================================
// Module   : fifo_serial_tx
// Purpose  : Drains a FIFO and sends each word as start / LSB-first data / stop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               enable,
    fifo_serial_tx_if.master        fifo,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done,
    output logic [7:0]              frame_cnt
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_BIT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    // Only reached when CLKS_PER_BIT >= 2; single-cycle stop bits are handled on entry.
    localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam bit                 c_STOP_ONE = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic                r_tx;
    logic                r_pop;
    logic                r_busy;
    logic                r_frame_done;
    logic [7:0]          r_frame_cnt;
    logic [DATA_W-1:0]   w_shift_nxt;

    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_pop        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_pop        <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (enable && !fifo.empty) begin
                        r_state <= S_POP;
                        r_pop   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift <= fifo.q;
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                            if (c_STOP_ONE) begin
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 8'd1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_nxt;
                            r_tx    <= w_shift_nxt[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // Registered pulse must land in the final stop cycle.
                        if (r_cnt == c_CNT_PRE) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                end
            endcase
        end
    end

    assign fifo.pop   = r_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
// ============================================================================
// Module   : tb_fifo_serial_tx
// Purpose  : Two DUTs (4 and 1 clocks per bit) with FIFO models and serial monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_serial_tx;

    localparam int DW = 4;

    logic clk;
    logic reset;
    logic en [2];

    int   words [2][256];
    int   wr [2];
    int   rd [2];
    int   lost [2];
    logic [DW-1:0] q_r [2];

    logic       tx_w [2];
    logic       busy_w [2];
    logic       fdone_w [2];
    logic [7:0] fcnt_w [2];
    logic       pop_w [2];
    logic       empty_w [2];

    // Monitor-owned state
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  rx_act [2];
    int  rx_t [2];
    int  rx_word [2];
    bit  post [2];
    bit  pend [2];
    int  pend_idx [2];
    int  pop_cnt [2];
    int  last_pop [2];
    bit  have_prev [2];
    int  n_frames [2];
    int  fcnt_m [2];
    bit  prev_en [2];
    bit  prev_empty [2];
    bit  done_seen = 0;

    // Stimulus-owned flags
    bit  chk_space [2];
    bit  idle_chk = 0;
    bit  done = 0;
    int  timeouts = 0;

    fifo_serial_tx_if #(.DATA_W(DW)) bus0 ();
    fifo_serial_tx_if #(.DATA_W(DW)) bus1 ();

    assign bus0.empty = (rd[0] == wr[0]);
    assign bus1.empty = (rd[1] == wr[1]);
    assign bus0.q     = q_r[0];
    assign bus1.q     = q_r[1];
    assign pop_w[0]   = bus0.pop;
    assign pop_w[1]   = bus1.pop;
    assign empty_w[0] = bus0.empty;
    assign empty_w[1] = bus1.empty;

    fifo_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[0]),
        .fifo       (bus0),
        .tx         (tx_w[0]),
        .busy       (busy_w[0]),
        .frame_done (fdone_w[0]),
        .frame_cnt  (fcnt_w[0])
    );

    fifo_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[1]),
        .fifo       (bus1),
        .tx         (tx_w[1]),
        .busy       (busy_w[1]),
        .frame_done (fdone_w[1]),
        .frame_cnt  (fcnt_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int ch);
        return (ch == 0) ? 4 : 1;
    endfunction

    // Behavioural FIFO: read data appears the cycle after pop.
    always @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (pop_w[ch] && rd[ch] < wr[ch]) begin
                q_r[ch] <= words[ch][rd[ch]][DW-1:0];
                rd[ch]  <= rd[ch] + 1;
            end
        end
    end

    task automatic chk(input string name, input int ch, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0d expected %0d (cycle %0d)", name, ch, act, exp, cyc);
        end
    endtask

    // Serial receiver and scoreboard: expected bits come from the word the FIFO handed out.
    always @(negedge clk) begin
        int cpb;
        int last;
        int k;
        int ebit;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            cpb  = cpb_of(ch);
            last = (DW + 2) * cpb - 1;
            if (!reset) begin
                chk("rst_tx",    ch, int'(tx_w[ch]),    1);
                chk("rst_busy",  ch, int'(busy_w[ch]),  0);
                chk("rst_pop",   ch, int'(pop_w[ch]),   0);
                chk("rst_fdone", ch, int'(fdone_w[ch]), 0);
                chk("rst_fcnt",  ch, int'(fcnt_w[ch]),  0);
                rx_act[ch] = 0; post[ch] = 0; pend[ch] = 0;
                have_prev[ch] = 0; fcnt_m[ch] = 0;
            end else begin
                if (!chk_space[ch]) have_prev[ch] = 0;
                if (pop_w[ch]) begin
                    chk("pop_enable",   ch, int'(prev_en[ch]),     1);
                    chk("pop_nonempty", ch, int'(prev_empty[ch]),  0);
                    chk("pop_single",   ch, int'(pend[ch]),        0);
                    if (chk_space[ch] && have_prev[ch])
                        chk("pop_spacing", ch, cyc - last_pop[ch], 3 + (DW + 2) * cpb);
                    have_prev[ch] = 1;
                    last_pop[ch]  = cyc;
                    pend[ch]      = 1;
                    pend_idx[ch]  = pop_cnt[ch];
                    pop_cnt[ch]++;
                end
                if (post[ch]) begin
                    chk("frame_cnt",  ch, int'(fcnt_w[ch]), fcnt_m[ch]);
                    chk("busy_fall",  ch, int'(busy_w[ch]), 0);
                    post[ch] = 0;
                end
                if (!rx_act[ch] && tx_w[ch] == 1'b0) begin
                    chk("start_latency", ch, cyc - last_pop[ch], 2);
                    chk("start_popped",  ch, int'(pend[ch]),     1);
                    rx_act[ch]  = 1;
                    rx_t[ch]    = 0;
                    rx_word[ch] = words[ch][pend_idx[ch]];
                    pend[ch]    = 0;
                end
                if (rx_act[ch]) begin
                    k = rx_t[ch] / cpb;
                    if (k == 0)       ebit = 0;
                    else if (k <= DW) ebit = (rx_word[ch] >> (k - 1)) & 1;
                    else              ebit = 1;
                    chk("tx_bit",     ch, int'(tx_w[ch]),    ebit);
                    chk("busy_frame", ch, int'(busy_w[ch]),  1);
                    chk("frame_done", ch, int'(fdone_w[ch]), (rx_t[ch] == last) ? 1 : 0);
                    if (rx_t[ch] == last) begin
                        n_frames[ch]++;
                        fcnt_m[ch] = (fcnt_m[ch] + 1) % 256;
                        post[ch]   = 1;
                        rx_act[ch] = 0;
                    end else begin
                        rx_t[ch]++;
                    end
                end else begin
                    chk("idle_tx",    ch, int'(tx_w[ch]),    1);
                    chk("idle_fdone", ch, int'(fdone_w[ch]), 0);
                end
                if (ch == 0 && idle_chk) begin
                    chk("empty_pop",  ch, int'(pop_w[ch]),  0);
                    chk("empty_busy", ch, int'(busy_w[ch]), 0);
                    chk("empty_fcnt", ch, int'(fcnt_w[ch]), 0);
                end
            end
            prev_en[ch]    = en[ch];
            prev_empty[ch] = empty_w[ch];
        end
        if (done && !done_seen) begin
            done_seen = 1;
            chk("wait_timeouts", 0, timeouts, 0);
            for (int ch = 0; ch < 2; ch++) begin
                chk("all_popped",   ch, pop_cnt[ch],        wr[ch]);
                chk("frames_total", ch, n_frames[ch],       wr[ch] - lost[ch]);
                chk("fcnt_final",   ch, int'(fcnt_w[ch]),   fcnt_m[ch]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int val);
        words[ch][wr[ch]] = val & ((1 << DW) - 1);
        wr[ch]++;
    endtask

    task automatic wait_frames(input int ch, input int target, input int budget);
        int i;
        i = 0;
        while (n_frames[ch] < target && i < budget) begin
            tick(1);
            i++;
        end
        if (n_frames[ch] < target) begin
            $display("FAIL wait_frames ch%0d: frames %0d expected %0d", ch, n_frames[ch], target);
            timeouts++;
        end
    endtask

    task automatic wait_bit(input int frames, input int k, input int budget);
        int i;
        i = 0;
        while (!(n_frames[0] == frames && rx_act[0] && rx_t[0] / 4 == k) && i < budget) begin
            tick(1);
            i++;
        end
        if (i >= budget) begin
            $display("FAIL wait_bit: frames %0d expected %0d at bit %0d", n_frames[0], frames, k);
            timeouts++;
        end
    endtask

    initial begin
        int base;
        en[0] = 1'b0; en[1] = 1'b0;
        chk_space[0] = 0; chk_space[1] = 0;
        for (int ch = 0; ch < 2; ch++) begin
            wr[ch] = 0; rd[ch] = 0; lost[ch] = 0;
            q_r[ch] = '0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        tick(3);
        reset = 1'b1;

        // Short-bit channel: two back-to-back words
        push(1, 4'h5);
        push(1, 4'hF);
        chk_space[1] = 1;
        en[1] = 1'b1;

        // Enabled with an empty FIFO: nothing may happen
        en[0] = 1'b1;
        idle_chk = 1;
        tick(50);
        idle_chk = 0;
        wait_frames(1, 2, 50);
        chk_space[1] = 0;

        // Single word 4'hA
        push(0, 4'hA);
        wait_frames(0, 1, 100);
        tick(5);

        // Pre-filled 1..15, continuous throughput
        chk_space[0] = 1;
        for (int v = 1; v <= 15; v++) push(0, v);
        wait_frames(0, 16, 15 * 27 + 100);
        chk_space[0] = 0;
        tick(60);

        // Enable dropped during data bit 1 of the second frame
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) push(0, int'($urandom_range(0, 15)));
        tick(5);
        en[0] = 1'b1;
        base = n_frames[0];
        wait_bit(base + 1, 2, 200);
        en[0] = 1'b0;
        wait_frames(0, base + 2, 100);
        tick(80);
        en[0] = 1'b1;
        wait_frames(0, base + 3, 100);
        tick(5);

        // Reset during the stop bit: first word lost, second sent cleanly
        base = n_frames[0];
        push(0, int'($urandom_range(0, 15)));
        push(0, int'($urandom_range(0, 15)));
        wait_bit(base, DW + 1, 200);
        reset = 1'b0;
        lost[0]++;
        tick(3);
        reset = 1'b1;
        wait_frames(0, base + 1, 100);
        tick(5);

        // Random pushes with random enable toggling
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) en[0] = ~en[0];
            if ($urandom_range(0, 1) == 1) push(0, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) push(1, int'($urandom_range(0, 15)));
            tick(int'($urandom_range(1, 40)));
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        wait_frames(0, wr[0] - lost[0], 30 * 27 + 100);
        wait_frames(1, wr[1] - lost[1], 200);
        tick(40);

        done = 1;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
